// File: rtl/force_result_serializer.sv
// -----------------------------------------------------------------------------
// force_result_serializer
//
// Takes the 512-bit result beats from force_pipeline (16 fp32 lanes per beat),
// buffers them in a small beat FIFO and replays them one lane per cycle on a
// 32-bit AXI-Stream with backpressure. The producer has no ready, so beats that
// arrive while the FIFO is full (and no pop happens on that edge) are dropped,
// and the sticky overflow flag is raised.
//
// Optional feature macro: SKIP_ZERO_LANES_EN
//   defined   : lanes whose bits[30:0] are zero (+0.0 / -0.0) are skipped; tuser
//               still carries the true lane index and tlast marks the last
//               non-zero lane. An all-zero beat is popped and dropped silently.
//   undefined : every lane 0..15 is emitted in order, tlast on lane 15.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   s_axis_tdata   input beat, lane i = bits [32i+31:32i]
//   s_axis_tvalid  input beat valid (no ready; producer never stalls)
//   m_axis_tdata   current output lane
//   m_axis_tvalid  output lane valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   final emitted lane of a beat
//   m_axis_tuser   lane index of m_axis_tdata
//   fifo_count     beats held in the FIFO (holding register excluded)
//   overflow       sticky, a beat was dropped since reset
//
// FSM:
//   state    | meaning
//   ST_IDLE  | holding register empty, pop the FIFO head when available
//   ST_SEND  | holding register has lanes left to emit
// -----------------------------------------------------------------------------
module force_result_serializer #(
  parameter int DATA_WIDTH = 512,
  parameter int LANE_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic [LANE_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [3:0]                    m_axis_tuser,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [3:0]            lane_q, lane_d;
  state_t                state_q, state_d;
  logic                  ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [NUM_LANES-1:0]  hold_nz;
  logic [NUM_LANES-1:0]  head_nz;
  logic [LANE_WIDTH-1:0] hold_lane [NUM_LANES];
  logic                  nxt_found;
  logic [3:0]            nxt_lane;
  logic                  first_found;
  logic [3:0]            first_lane;
  logic                  last_lane;
  logic                  hs;
  logic                  pop;
  logic                  push;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_CNT);

  // Lane view of HOLD plus per-lane "emit this lane" masks for HOLD and head.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      hold_lane[i] = hold_q[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef SKIP_ZERO_LANES_EN
      // sign bit ignored so both +0.0 and -0.0 count as zero
      hold_nz[i]   = |hold_q[i*LANE_WIDTH +: LANE_WIDTH-1];
      head_nz[i]   = |head[i*LANE_WIDTH +: LANE_WIDTH-1];
`else
      hold_nz[i]   = 1'b1;
      head_nz[i]   = 1'b1;
`endif
    end
  end

  // Next emitted lane above the current one, and first emitted lane of the
  // head beat. Scanning downward leaves the lowest matching index.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_lane    = '0;
    first_found = 1'b0;
    first_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (hold_nz[i] && (4'(i) > lane_q)) begin
        nxt_found = 1'b1;
        nxt_lane  = 4'(i);
      end
      if (head_nz[i]) begin
        first_found = 1'b1;
        first_lane  = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    hold_d        = hold_q;
    pop           = 1'b0;
    m_axis_tvalid = (state_q == ST_SEND);
    last_lane     = !nxt_found;
    hs            = m_axis_tvalid && m_axis_tready;

    case (state_q)
      ST_IDLE: begin
        pop = !fifo_empty;
      end
      ST_SEND: begin
        if (hs) begin
          if (last_lane) begin
            // end of beat: refill from the FIFO on the same edge, no bubble
            pop     = !fifo_empty;
            state_d = ST_IDLE;
            lane_d  = '0;
          end else begin
            lane_d = nxt_lane;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An all-zero beat (skip mode only) is consumed here and never shown.
    if (pop) begin
      hold_d  = head;
      lane_d  = first_lane;
      state_d = first_found ? ST_SEND : ST_IDLE;
    end
  end

  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign push = s_axis_tvalid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (s_axis_tvalid && !push) begin
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      lane_q   <= '0;
      state_q  <= ST_IDLE;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      lane_q   <= lane_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
    end
  end

  // Beat storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis_tdata = hold_lane[lane_q];
  assign m_axis_tuser = lane_q;
  assign m_axis_tlast = m_axis_tvalid && last_lane;
  assign fifo_count   = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_force_result_serializer.sv
module tb_force_result_serializer;

  localparam int DW    = 512;
  localparam int LW    = 32;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic [LW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [3:0]    m_axis_tuser;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  force_result_serializer #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .fifo_count(fifo_count), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of stored beats plus the list of lane indices still
  // to be emitted from the beat currently being serialized.
  logic [DW-1:0] fq [$];
  logic [DW-1:0] cur_data;
  int            cur_q [$];
  logic          m_ovf;

  logic          prev_stall;
  logic [LW-1:0] prev_data;
  logic [3:0]    prev_user;
  int            hs_cnt;
  int            peak_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit lane_emitted(input logic [DW-1:0] b, input int i);
`ifdef SKIP_ZERO_LANES_EN
    return b[i*LW +: LW-1] != '0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    bit m_hs, m_pop;
    if (rst) begin
      fq.delete();
      cur_q.delete();
      cur_data = '0;
      m_ovf    = 1'b0;
    end else begin
      m_hs  = (cur_q.size() > 0) && m_axis_tready;
      m_pop = (fq.size() > 0) && ((cur_q.size() == 0) || (m_hs && cur_q.size() == 1));
      if (m_hs) void'(cur_q.pop_front());
      if (m_pop) begin
        cur_data = fq.pop_front();
        cur_q.delete();
        for (int i = 0; i < NL; i++)
          if (lane_emitted(cur_data, i)) cur_q.push_back(i);
      end
      if (s_axis_tvalid) begin
        if (fq.size() < DEPTH) fq.push_back(s_axis_tdata);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit exp_v;
    exp_v = cur_q.size() > 0;
    check("tvalid", m_axis_tvalid, exp_v);
    check("tlast", m_axis_tlast, exp_v && (cur_q.size() == 1));
    check("fifo_count", fifo_count, fq.size());
    check("overflow", overflow, m_ovf);
    if (exp_v) begin
      check("tdata", m_axis_tdata, cur_data[cur_q[0]*LW +: LW]);
      check("tuser", m_axis_tuser, cur_q[0]);
    end
    if (prev_stall) begin
      check("stable_tdata", m_axis_tdata, prev_data);
      check("stable_tuser", m_axis_tuser, prev_user);
    end
    if (int'(fifo_count) > peak_cnt) peak_cnt = int'(fifo_count);
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
    rst           = r;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    prev_stall    = m_axis_tvalid && !rdy && !r;
    prev_data     = m_axis_tdata;
    prev_user     = m_axis_tuser;
    if (m_axis_tvalid && rdy && !r) hs_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] fp32_of(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    for (int i = 0; i < NL; i++) begin
      case ($urandom_range(0, 3))
        0:       b[i*LW +: LW] = 32'h0000_0000;
        1:       b[i*LW +: LW] = 32'h8000_0000;
        default: b[i*LW +: LW] = $urandom;
      endcase
    end
    return b;
  endfunction

  initial begin
    logic [DW-1:0] beat, beat2;
    bit found;

    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    cur_data = '0; m_ovf = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_user = '0;
    hs_cnt = 0; peak_cnt = 0;
    @(negedge clk);

    // reset
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);

    // single beat, lane 0 = 1.0, latency 2 cycles
    beat = '0;
    beat[31:0] = 32'h3f80_0000;
    step(1'b0, 1'b1, beat, 1'b1);
    check("lat_edge1_valid", m_axis_tvalid, 0);
    step(1'b0, 1'b0, '0, 1'b1);
    check("lat_edge2_valid", m_axis_tvalid, 1);
    hs_cnt = 0;
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, '0, 1'b1);
`ifndef SKIP_ZERO_LANES_EN
    check("single_beat_lanes", hs_cnt, 16);
`endif

    // two back-to-back beats, lane i = i+1
    for (int i = 0; i < NL; i++) beat[i*LW +: LW] = fp32_of(i + 1);
    hs_cnt = 0; peak_cnt = 0;
    step(1'b0, 1'b1, beat, 1'b1);
    step(1'b0, 1'b1, beat, 1'b1);
    for (int c = 0; c < 36; c++) step(1'b0, 1'b0, '0, 1'b1);
    check("two_beat_lanes", hs_cnt, 32);
    check("two_beat_peak", peak_cnt, 1);
    check("two_beat_ovf", overflow, 0);

    // stalled output, 6 beats pushed: last one dropped
    for (int b = 0; b < 6; b++) step(1'b0, 1'b1, rand_beat(), 1'b0);
    check("stall_count", fifo_count, DEPTH);
    check("stall_ovf", overflow, 1);
    hs_cnt = 0;
    for (int c = 0; c < 90; c++) step(1'b0, 1'b0, '0, 1'b1);
`ifndef SKIP_ZERO_LANES_EN
    check("stall_drain_lanes", hs_cnt, 80);
`endif
    check("ovf_sticky", overflow, 1);

    // random ready during a beat
    step(1'b0, 1'b1, rand_beat(), 1'b0);
    for (int c = 0; c < 60; c++) step(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, '0, 1'b1);

    // reset mid-beat with two beats queued
    for (int i = 0; i < NL; i++) beat2[i*LW +: LW] = 32'h4000_0000 + i;
    for (int b = 0; b < 3; b++) step(1'b0, 1'b1, beat2, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_axis_tvalid && m_axis_tuser == 4'd7) found = 1'b1;
      else step(1'b0, 1'b0, '0, 1'b1);
    end
    check("reach_lane7", found, 1);
    check("queued_before_rst", fifo_count, 2);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_rst_valid", m_axis_tvalid, 0);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_ovf", overflow, 0);
    step(1'b0, 1'b1, beat2, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("restart_lane0", m_axis_tuser, 0);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, '0, 1'b1);

`ifdef SKIP_ZERO_LANES_EN
    // only lanes 3 and 9 non-zero, then an all-zero beat
    beat = '0;
    beat[3*LW +: LW] = 32'h4120_0000;
    beat[9*LW +: LW] = 32'hc000_0000;
    hs_cnt = 0;
    step(1'b0, 1'b1, beat, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("skip_first_user", m_axis_tuser, 3);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, '0, 1'b1);
    check("skip_lanes", hs_cnt, 2);
    beat = '0;
    beat[5*LW +: LW] = 32'h8000_0000;
    hs_cnt = 0;
    step(1'b0, 1'b1, beat, 1'b0);
    check("zero_beat_queued", fifo_count, 1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("zero_beat_popped", fifo_count, 0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, '0, 1'b1);
    check("zero_beat_lanes", hs_cnt, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++)
      step(1'b0, 1'($urandom_range(0, 99) < 8), rand_beat(), 1'($urandom_range(0, 99) < 70));
    for (int c = 0; c < 100; c++) step(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
